mac_dot_seq: RTL and testbench
==============================

// Module: mac_dot_seq
// PURPOSE
//  Upstream sequencer for MAC_top: computes acc = acc0 + sum(B[k]*C[k]), k=0..K-1.
//  Operands are FP16 pairs; accumulation is FP32, using MAC mixed mode 2'b10 (A fp32, B/C fp16).
//  Element pairs arrive over a valid/ready stream and are issued to the MAC one at a time.
//  The running accumulator is fed back to A, and the final sum plus sticky flags leave on a
//  valid/ready result port. Sits between the operand buffers and MAC_top.
// PARAMETERS
//  KW       8   width of the element-count field (K max = 2**KW-1)
//  MAC_LAT  2   MAC_top latency in cycles (issue cycle n -> result visible in cycle n+MAC_LAT)
// PORTS
//  clk           in   1   clock
//  rst_n         in   1   async active-low reset
//  start_i       in   1   begin a dot product; sampled only in IDLE
//  len_i         in   KW  element count K, latched on start
//  acc0_i        in   32  FP32 initial accumulator, latched on start
//  rm_i          in   3   rounding mode, latched on start
//  busy_o        out  1   high from the start cycle +1 until the result is accepted
//  elem_valid_i  in   1   element pair valid
//  elem_ready_o  out  1   element pair accepted this cycle (valid & ready = issue)
//  elem_b_i      in   16  FP16 B operand
//  elem_c_i      in   16  FP16 C operand
//  mac_A_o       out  32  to MAC A_i (accumulator)
//  mac_B_o       out  32  to MAC B_i ({16'h0, elem_b_i})
//  mac_C_o       out  32  to MAC C_i ({16'h0, elem_c_i})
//  mac_mode_o    out  2   to MAC fp_mode_i; constant 2'b10
//  mac_rm_o      out  3   to MAC rm_i (latched rm)
//  mac_R32_i     in   32  from MAC R32_o
//  mac_flags_i   in   5   from MAC flags_o {NV,DZ,OF,UF,NX}
//  res_valid_o   out  1   result valid
//  res_ready_i   in   1   result consumer ready
//  res_o         out  32  FP32 dot-product result
//  res_flags_o   out  5   OR of all MAC flags across the K issues
// BEHAVIOUR
//  Reset (async): state=IDLE; acc, count, flags, latched len/rm = 0; all outputs 0,
//   except mac_mode_o=2'b10. In-flight MAC results are discarded (tracker cleared).
//  FSM IDLE -> ISSUE -> WAIT -> (ISSUE | DONE) -> IDLE.
//  IDLE: elem_ready_o=0. On start_i: latch len, rm; acc<=acc0_i; flags<=0; count<=0.
//   K==0 -> DONE, else -> ISSUE.
//  ISSUE: elem_ready_o=1 and mac_A_o=acc. mac_B_o/mac_C_o are driven from elem_* combinationally.
//   On valid&ready: set tracker bit, count<=count+1 -> WAIT. Without valid: stay, mac_B/C_o=0.
//  WAIT: elem_ready_o=0; operand outputs 0. The tracker is a MAC_LAT-deep valid shift register.
//   In the cycle its output bit is set (issue+MAC_LAT): acc<=mac_R32_i, flags<=flags|mac_flags_i.
//   Then go to DONE if count==len, else to ISSUE.
//   MAC output is sampled only in that cycle; all other cycles are ignored.
//  Throughput: one element per MAC_LAT+1 cycles (no forwarding).
//   Issue cycles for consecutive elements are n, n+3, n+6... when valid is held high.
//  DONE: res_valid_o=1, res_o=acc, res_flags_o=flags. These are held stable until res_ready_i.
//   On valid&ready -> IDLE, busy_o=0 next cycle.
//  start_i while not IDLE is ignored. res_ready_i outside DONE is ignored.
//  count is KW bits; len=2**KW-1 completes without wrap.
//  NaN/Inf propagate through the MAC unchanged; the sequencer does no FP checks.
// STRUCTURE
//  mac_pkg: fp_mode_e {FP32=2'b00, FP16=2'b01, MIX=2'b10}; rm_e {RNE,RTZ,RDN,RUP,RMM};
//   MAC_LAT localparam; flag index constants NV/DZ/OF/UF/NX. MAC_top and this block both import it.
//  Sub-module: mac_lat_tracker (valid delay line, depth MAC_LAT, async clear). FSM stays inline.
// TESTING
//  acc0=0x00000000, K=2, (3C00,4000),(4000,4000) -> res_o=0x40C00000 (6.0), flags=0.
//   Also check issues are 3 cycles apart.
//  K=0, acc0=0x40400000, start -> res_valid_o 1 cycle after start, res_o=0x40400000,
//   and no mac issue occurs.
//  elem_valid_i gapped 5 cycles between pairs, K=3 of (3C00,3C00), acc0=0x3F800000
//   -> res_o=0x40800000 (4.0).
//  Pair (7C00,0000) (Inf*0) -> res_o is a NaN (exp 0xFF, mantissa!=0), res_flags_o[4] (NV)=1.
//   The flag persists after later normal pairs.
//  res_ready_i held low 10 cycles in DONE -> res_o/res_flags_o stable. start_i pulsed there is ignored.
//  rst_n asserted in WAIT mid-run -> all outputs 0 immediately. A following run of K=1
//   (3C00,4000), acc0=0 -> res_o=0x40000000, unaffected by the stale MAC result.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared MAC definitions: operand formats, rounding modes, pipeline latency
// and flag bit positions, used by MAC_top and its sequencers.
package mac_pkg;

  typedef enum logic [1:0] {
    FP32 = 2'b00,
    FP16 = 2'b01,
    MIX  = 2'b10
  } fp_mode_e;

  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RDN = 3'd2,
    RUP = 3'd3,
    RMM = 3'd4
  } rm_e;

  localparam int MAC_LAT = 2;

  // Bit positions inside the {NV,DZ,OF,UF,NX} flag vector
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/mac_lat_tracker.sv
// Valid delay line matching the MAC pipeline: ret_o rises exactly DEPTH
// cycles after issue_i, so the owner knows which cycle carries its result.
module mac_lat_tracker #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic issue_i,
  output logic ret_o
);

  logic [DEPTH-1:0] sr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        sr_q[i] <= sr_q[i-1];
      end
      sr_q[0] <= issue_i;
    end
  end

  assign ret_o = sr_q[DEPTH-1];

endmodule

// File: rtl/mac_dot_seq.sv
// Dot-product sequencer for MAC_top: feeds FP16 pairs one at a time in mixed
// mode, loops the FP32 result back as the accumulator, and returns sum + flags.
module mac_dot_seq
  import mac_pkg::*;
#(
  parameter int KW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic [KW-1:0] len_i,
  input  logic [31:0]   acc0_i,
  input  logic [2:0]    rm_i,
  output logic          busy_o,
  input  logic          elem_valid_i,
  output logic          elem_ready_o,
  input  logic [15:0]   elem_b_i,
  input  logic [15:0]   elem_c_i,
  output logic [31:0]   mac_A_o,
  output logic [31:0]   mac_B_o,
  output logic [31:0]   mac_C_o,
  output logic [1:0]    mac_mode_o,
  output logic [2:0]    mac_rm_o,
  input  logic [31:0]   mac_R32_i,
  input  logic [4:0]    mac_flags_i,
  output logic          res_valid_o,
  input  logic          res_ready_i,
  output logic [31:0]   res_o,
  output logic [4:0]    res_flags_o
);

  seq_state_e    state_q;
  logic [KW-1:0] len_q;
  logic [KW-1:0] count_q;
  logic [KW-1:0] count_d;
  logic [31:0]   acc_q;
  logic [4:0]    flags_q;
  logic [2:0]    rm_q;
  logic          issue;
  logic          mac_ret;

  assign issue   = (state_q == S_ISSUE) && elem_valid_i;
  assign count_d = count_q + KW'(1);

  mac_lat_tracker #(
    .DEPTH (MAC_LAT)
  ) u_tracker (
    .clk     (clk),
    .rst_n   (rst_n),
    .issue_i (issue),
    .ret_o   (mac_ret)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      count_q <= '0;
      acc_q   <= '0;
      flags_q <= '0;
      rm_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            len_q   <= len_i;
            rm_q    <= rm_i;
            acc_q   <= acc0_i;
            flags_q <= '0;
            count_q <= '0;
            state_q <= (len_i == '0) ? S_DONE : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (elem_valid_i) begin
            count_q <= count_d;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          // MAC output is only trusted in the cycle our own issue emerges
          if (mac_ret) begin
            acc_q   <= mac_R32_i;
            flags_q <= flags_q | mac_flags_i;
            state_q <= (count_q == len_q) ? S_DONE : S_ISSUE;
          end
        end
        S_DONE: begin
          if (res_ready_i) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o       = (state_q != S_IDLE);
  assign elem_ready_o = (state_q == S_ISSUE);
  assign mac_A_o      = (state_q == S_ISSUE) ? acc_q : '0;
  assign mac_B_o      = issue ? {16'h0, elem_b_i} : '0;
  assign mac_C_o      = issue ? {16'h0, elem_c_i} : '0;
  assign mac_mode_o   = MIX;
  assign mac_rm_o     = rm_q;
  assign res_valid_o  = (state_q == S_DONE);
  assign res_o        = (state_q == S_DONE) ? acc_q : '0;
  assign res_flags_o  = (state_q == S_DONE) ? flags_q : '0;

endmodule

// File: tb/tb_mac_dot_seq.sv
// Bench for mac_dot_seq: a latency-2 behavioural MAC stub plus a scoreboard
// fed with dot products computed directly in real arithmetic.
`timescale 1ns/1ps
module tb_mac_dot_seq;
  import mac_pkg::*;

  localparam int KW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic [KW-1:0] len_i = '0;
  logic [31:0]   acc0_i = '0;
  logic [2:0]    rm_i = '0;
  logic          busy_o;
  logic          elem_valid_i = 1'b0;
  logic          elem_ready_o;
  logic [15:0]   elem_b_i = '0;
  logic [15:0]   elem_c_i = '0;
  logic [31:0]   mac_A_o, mac_B_o, mac_C_o;
  logic [1:0]    mac_mode_o;
  logic [2:0]    mac_rm_o;
  logic [31:0]   mac_R32_i = '0;
  logic [4:0]    mac_flags_i = '0;
  logic          res_valid_o;
  logic          res_ready_i = 1'b0;
  logic [31:0]   res_o;
  logic [4:0]    res_flags_o;

  always #5 clk = ~clk;

  mac_dot_seq #(.KW(KW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .len_i        (len_i),
    .acc0_i       (acc0_i),
    .rm_i         (rm_i),
    .busy_o       (busy_o),
    .elem_valid_i (elem_valid_i),
    .elem_ready_o (elem_ready_o),
    .elem_b_i     (elem_b_i),
    .elem_c_i     (elem_c_i),
    .mac_A_o      (mac_A_o),
    .mac_B_o      (mac_B_o),
    .mac_C_o      (mac_C_o),
    .mac_mode_o   (mac_mode_o),
    .mac_rm_o     (mac_rm_o),
    .mac_R32_i    (mac_R32_i),
    .mac_flags_i  (mac_flags_i),
    .res_valid_o  (res_valid_o),
    .res_ready_i  (res_ready_i),
    .res_o        (res_o),
    .res_flags_o  (res_flags_o)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  flags;
    bit          nan;
  } exp_t;

  exp_t        sb[$];
  int          issue_cyc[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_res = 0;
  int          cyc = 0;
  logic [2:0]  cur_rm = '0;
  logic [15:0] b_arr [256];
  logic [15:0] c_arr [256];
  logic [15:0] vtab [10];

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- FP helpers (plain arithmetic) ----------------
  function automatic real pow2(input int n);
    real p;
    p = 1.0;
    if (n >= 0) for (int i = 0; i < n; i++) p = p * 2.0;
    else        for (int i = 0; i < -n; i++) p = p / 2.0;
    return p;
  endfunction

  function automatic real fp16_to_real(input logic [15:0] h);
    real m, v;
    int  e;
    e = int'(h[14:10]);
    m = real'(h[9:0]) / 1024.0;
    if (e == 0) v = m * pow2(-14);
    else        v = (1.0 + m) * pow2(e - 15);
    return h[15] ? -v : v;
  endfunction

  function automatic real fp32_to_real(input logic [31:0] a);
    real m, v;
    int  e;
    e = int'(a[30:23]);
    m = real'(a[22:0]) / 8388608.0;
    if (e == 0) v = m * pow2(-126);
    else        v = (1.0 + m) * pow2(e - 127);
    return a[31] ? -v : v;
  endfunction

  function automatic logic [31:0] real_to_fp32(input real r);
    logic [63:0] d;
    int          e;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    e = int'(d[62:52]) - 1023 + 127;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic bit is_inf16(input logic [15:0] h);
    return (h[14:10] == 5'h1F) && (h[9:0] == 10'h0);
  endfunction

  function automatic bit is_zero16(input logic [15:0] h);
    return h[14:0] == 15'h0;
  endfunction

  function automatic bit is_nan16(input logic [15:0] h);
    return (h[14:10] == 5'h1F) && (h[9:0] != 10'h0);
  endfunction

  // Stub flag rule: NX whenever both mantissa MSBs are set, NV on Inf*0
  function automatic logic [4:0] stub_flags(input logic [15:0] b, input logic [15:0] c);
    logic [4:0] f;
    f = '0;
    f[4] = (is_inf16(b) && is_zero16(c)) || (is_zero16(b) && is_inf16(c));
    f[0] = b[9] & c[9];
    return f;
  endfunction

  task automatic mac_model(input logic [31:0] a, input logic [15:0] b, input logic [15:0] c,
                           output logic [31:0] r, output logic [4:0] f);
    bit nan;
    f   = stub_flags(b, c);
    nan = f[4] || is_nan16(b) || is_nan16(c) || ((a[30:23] == 8'hFF) && (a[22:0] != 0));
    if (nan) r = 32'h7FC00000;
    else     r = real_to_fp32(fp32_to_real(a) + fp16_to_real(b) * fp16_to_real(c));
  endtask

  function automatic exp_t dot_ref(input logic [31:0] acc0, input int k);
    exp_t e;
    real  s;
    s       = fp32_to_real(acc0);
    e.flags = '0;
    e.nan   = 1'b0;
    for (int i = 0; i < k; i++) begin
      e.flags = e.flags | stub_flags(b_arr[i], c_arr[i]);
      s = s + fp16_to_real(b_arr[i]) * fp16_to_real(c_arr[i]);
    end
    e.nan = e.flags[4];
    e.res = e.nan ? 32'h7FC00000 : real_to_fp32(s);
    return e;
  endfunction

  // ---------------- MAC stub: latency 2, junk on non-result cycles ----------------
  bit          iss_v [3] = '{1'b0, 1'b0, 1'b0};
  logic [31:0] iss_r [3];
  logic [4:0]  iss_f [3];

  always @(negedge clk) begin : mac_stub
    logic [31:0] r;
    logic [4:0]  f;
    mac_model(mac_A_o, mac_B_o[15:0], mac_C_o[15:0], r, f);
    iss_v[2] = iss_v[1]; iss_r[2] = iss_r[1]; iss_f[2] = iss_f[1];
    iss_v[1] = iss_v[0]; iss_r[1] = iss_r[0]; iss_f[1] = iss_f[0];
    iss_v[0] = elem_valid_i && elem_ready_o && rst_n;
    iss_r[0] = r;
    iss_f[0] = f;
    if (iss_v[2]) begin
      mac_R32_i   = iss_r[2];
      mac_flags_i = iss_f[2];
    end else begin
      mac_R32_i   = $urandom;
      mac_flags_i = 5'($urandom);
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  always @(negedge clk) begin : issue_mon
    if (rst_n && elem_valid_i && elem_ready_o) begin
      issue_cyc.push_back(cyc);
      check("mac_rm", 32'(mac_rm_o), 32'(cur_rm));
      check("mac_mode", 32'(mac_mode_o), 32'h2);
      check("mac_C", mac_C_o, {16'h0, elem_c_i});
    end
  end

  always @(negedge clk) begin : res_mon
    exp_t e;
    if (rst_n && res_valid_o && res_ready_i) begin
      if (sb.size() == 0) begin
        timeout_fail("unexpected_result");
      end else begin
        e = sb.pop_front();
        if (e.nan) begin
          n_checks++;
          if (!(res_o[30:23] == 8'hFF && res_o[22:0] != 23'h0)) begin
            n_fail++;
            $display("FAIL res_nan: got %h expected a NaN", res_o);
          end
        end else begin
          check("res_o", res_o, e.res);
        end
        check("res_flags", 32'(res_flags_o), 32'(e.flags));
        $display("result %0d: res=%h flags=%b", n_res, res_o, res_flags_o);
        n_res++;
      end
    end
  end

  task automatic chk_outs_zero(input string tag);
    check({tag, "_busy"}, 32'(busy_o), 32'h0);
    check({tag, "_elem_ready"}, 32'(elem_ready_o), 32'h0);
    check({tag, "_mac_A"}, mac_A_o, 32'h0);
    check({tag, "_mac_B"}, mac_B_o, 32'h0);
    check({tag, "_mac_rm"}, 32'(mac_rm_o), 32'h0);
    check({tag, "_res_valid"}, 32'(res_valid_o), 32'h0);
    check({tag, "_res_o"}, res_o, 32'h0);
    check({tag, "_res_flags"}, 32'(res_flags_o), 32'h0);
    check({tag, "_mode"}, 32'(mac_mode_o), 32'h2);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic start_run(input logic [31:0] acc0, input int k);
    @(posedge clk); #1;
    cur_rm  = 3'($urandom_range(0, 4));
    start_i = 1'b1;
    len_i   = KW'(k);
    acc0_i  = acc0;
    rm_i    = cur_rm;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic feed(input logic [15:0] b, input logic [15:0] c, input int gap);
    int t;
    repeat (gap) begin @(posedge clk); #1; end
    elem_valid_i = 1'b1;
    elem_b_i     = b;
    elem_c_i     = c;
    t = 0;
    @(negedge clk);
    while (!elem_ready_o && t < 50) begin @(negedge clk); t++; end
    if (!elem_ready_o) timeout_fail("elem_ready");
    @(posedge clk); #1;
    elem_valid_i = 1'b0;
    elem_b_i     = '0;
    elem_c_i     = '0;
  endtask

  task automatic wait_res();
    int t;
    t = 0;
    @(negedge clk);
    while (!res_valid_o && t < 2000) begin @(negedge clk); t++; end
    if (!res_valid_o) timeout_fail("res_valid");
  endtask

  task automatic accept(input int dly);
    repeat (dly + 1) begin @(posedge clk); #1; end
    res_ready_i = 1'b1;
    @(posedge clk); #1;
    res_ready_i = 1'b0;
  endtask

  task automatic do_run(input logic [31:0] acc0, input int k, input int gap, input int rdy,
                        input exp_t e);
    sb.push_back(e);
    start_run(acc0, k);
    for (int i = 0; i < k; i++) feed(b_arr[i], c_arr[i], gap);
    wait_res();
    accept(rdy);
  endtask

  function automatic exp_t mk(input logic [31:0] r, input logic [4:0] f, input bit nan);
    exp_t e;
    e.res = r; e.flags = f; e.nan = nan;
    return e;
  endfunction

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n_before;
    int k;
    logic [31:0] a0;
    vtab[0] = 16'h3C00; vtab[1] = 16'h4000; vtab[2] = 16'h3800; vtab[3] = 16'h4200;
    vtab[4] = 16'h4400; vtab[5] = 16'hBC00; vtab[6] = 16'hC000; vtab[7] = 16'h3400;
    vtab[8] = 16'h0000; vtab[9] = 16'h3E00;

    // reset state
    #12;
    chk_outs_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_outs_zero("idle");

    // K=2 with valid held: 1*2 + 2*2 = 6.0, issues three cycles apart
    issue_cyc.delete();
    b_arr[0] = 16'h3C00; c_arr[0] = 16'h4000;
    b_arr[1] = 16'h4000; c_arr[1] = 16'h4000;
    do_run(32'h0, 2, 0, 0, mk(32'h40C00000, 5'b0, 1'b0));
    check("issue_count_k2", 32'(issue_cyc.size()), 32'd2);
    if (issue_cyc.size() == 2) check("issue_spacing", 32'(issue_cyc[1] - issue_cyc[0]), 32'd3);

    // K=0: result one cycle after start, no issue
    n_before = issue_cyc.size();
    sb.push_back(mk(32'h40400000, 5'b0, 1'b0));
    start_run(32'h40400000, 0);
    @(negedge clk);
    check("k0_res_valid", 32'(res_valid_o), 32'h1);
    check("k0_busy", 32'(busy_o), 32'h1);
    accept(0);
    check("k0_no_issue", 32'(issue_cyc.size()), 32'(n_before));

    // gapped valid: 1 + 3*(1*1) = 4.0
    for (int i = 0; i < 3; i++) begin b_arr[i] = 16'h3C00; c_arr[i] = 16'h3C00; end
    do_run(32'h3F800000, 3, 5, 1, mk(32'h40800000, 5'b0, 1'b0));

    // Inf*0 first, then normal pairs: NaN survives, NV sticks
    b_arr[0] = 16'h7C00; c_arr[0] = 16'h0000;
    b_arr[1] = 16'h3C00; c_arr[1] = 16'h4000;
    b_arr[2] = 16'h4000; c_arr[2] = 16'h4000;
    do_run(32'h0, 3, 0, 0, mk(32'h7FC00000, 5'b10000, 1'b1));

    // result held in DONE for 10 cycles; start pulse there is ignored
    sb.push_back(mk(32'h40900000, 5'b00001, 1'b0));
    start_run(32'h0, 1);
    feed(16'h4200, 16'h3E00, 0);
    wait_res();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i == 4) begin start_i = 1'b1; len_i = KW'(5); end
      if (i == 5) start_i = 1'b0;
      @(negedge clk);
      check("hold_valid", 32'(res_valid_o), 32'h1);
      check("hold_res", res_o, 32'h40900000);
      check("hold_flags", 32'(res_flags_o), 32'h1);
    end
    accept(0);
    @(negedge clk);
    check("after_accept_busy", 32'(busy_o), 32'h0);
    @(negedge clk);
    check("ignored_start_busy", 32'(busy_o), 32'h0);
    check("ignored_start_ready", 32'(elem_ready_o), 32'h0);

    // async reset while waiting on the MAC, then a clean run
    start_run(32'h0, 1);
    feed(16'h4400, 16'h4400, 0);
    rst_n = 1'b0;
    #1;
    chk_outs_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    b_arr[0] = 16'h3C00; c_arr[0] = 16'h4000;
    do_run(32'h0, 1, 0, 0, mk(32'h40000000, 5'b0, 1'b0));

    // randomized runs against the real-arithmetic reference
    for (int r = 0; r < 20; r++) begin
      k  = $urandom_range(1, 8);
      a0 = real_to_fp32(fp16_to_real(vtab[$urandom_range(0, 9)]));
      for (int i = 0; i < k; i++) begin
        b_arr[i] = vtab[$urandom_range(0, 9)];
        c_arr[i] = vtab[$urandom_range(0, 9)];
      end
      do_run(a0, k, $urandom_range(0, 3), $urandom_range(0, 3), dot_ref(a0, k));
    end

    // maximum length completes without the count wrapping
    for (int i = 0; i < 255; i++) begin
      b_arr[i] = vtab[$urandom_range(0, 9)];
      c_arr[i] = vtab[$urandom_range(0, 9)];
    end
    n_before = issue_cyc.size();
    do_run(32'h3F800000, 255, 0, 0, dot_ref(32'h3F800000, 255));
    check("k255_issues", 32'(issue_cyc.size() - n_before), 32'd255);

    repeat (5) @(posedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
